// File: rtl/muldiv_issue_ctrl_if.sv
// Execute-stage request/response and shared mul/div unit handshake.
// master = issue controller, slave = pipeline and unit side.
interface muldiv_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  logic              md_valid;
  logic              md_mode;
  logic [XLEN-1:0]   md_a;
  logic [XLEN-1:0]   md_b;
  logic              md_ready;
  logic [2*XLEN-1:0] md_out;

  modport master (
    input  req_valid, req_op, req_rs1, req_rs2,
    output stall, resp_valid, resp_data,
    output md_valid, md_mode, md_a, md_b,
    input  md_ready, md_out
  );

  modport slave (
    output req_valid, req_op, req_rs1, req_rs2,
    input  stall, resp_valid, resp_data,
    input  md_valid, md_mode, md_a, md_b,
    output md_ready, md_out
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// RV32M issue controller: sign handling around an unsigned
// iterative mul/div unit, with local div-by-zero/overflow.
module muldiv_issue_ctrl #(
  parameter int XLEN = 32
) (
  input logic                 clk,
  input logic                 rst,
  muldiv_issue_ctrl_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [2:0]      op;
  logic            s1;
  logic            s2;
  logic            mode;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] res;

  logic            sgn1;
  logic            sgn2;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] byp_res;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (bus.req_op)
      MULH, DIV, REM: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      MULHSU: sgn1 = 1'b1;
      default: ;
    endcase
  end

  assign neg1 = sgn1 & bus.req_rs1[XLEN-1];
  assign neg2 = sgn2 & bus.req_rs2[XLEN-1];
  assign a_in = neg1 ? -bus.req_rs1 : bus.req_rs1;
  assign b_in = neg2 ? -bus.req_rs2 : bus.req_rs2;

  assign div_zero = bus.req_op[2] & (bus.req_rs2 == '0);
  assign div_ovf  = bus.req_op[2] & ~bus.req_op[0]
                  & (bus.req_rs1 == MIN_INT)
                  & (bus.req_rs2 == '1);

  always_comb begin
    byp_res = '0;
    if (div_zero)
      byp_res = bus.req_op[1] ? bus.req_rs1 : '1;
    else if (!bus.req_op[1])
      byp_res = MIN_INT;
  end

  // Full 64-bit product is conditionally negated so MUL keeps
  // the untouched low word and high-word ops share one negator.
  logic              prod_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   corr;

  always_comb begin
    prod_neg = 1'b0;
    unique case (op)
      MULH:    prod_neg = s1 ^ s2;
      MULHSU:  prod_neg = s1;
      default: ;
    endcase
  end

  assign prod = prod_neg ? -bus.md_out : bus.md_out;
  assign quo  = bus.md_out[XLEN-1:0];
  assign rem  = bus.md_out[2*XLEN-1:XLEN];

  always_comb begin
    corr = '0;
    unique case (op)
      MUL:     corr = prod[XLEN-1:0];
      MULH,
      MULHSU,
      MULHU:   corr = prod[2*XLEN-1:XLEN];
      DIV:     corr = (s1 ^ s2) ? -quo : quo;
      DIVU:    corr = quo;
      REM:     corr = s1 ? -rem : rem;
      default: corr = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      mode  <= 1'b0;
      a_mag <= '0;
      b_mag <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op    <= bus.req_op;
            s1    <= neg1;
            s2    <= neg2;
            mode  <= bus.req_op[2];
            a_mag <= a_in;
            b_mag <= b_in;
            if (div_zero || div_ovf) begin
              res   <= byp_res;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.md_ready) begin
            res   <= corr;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall = ((state == IDLE) & bus.req_valid)
                   | (state == ISSUE)
                   | (state == WAIT);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = res;
  assign bus.md_valid   = (state == ISSUE);
  assign bus.md_mode    = mode;
  assign bus.md_a       = a_mag;
  assign bus.md_b       = b_mag;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl with a behavioural
// unsigned mul/div unit and directed hand-computed vectors.
module tb_muldiv_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_issue_ctrl_if #(.XLEN(32)) bus ();

  muldiv_issue_ctrl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int issues = 0;
  int n_resp = 0;
  int unit_dly = 33;
  logic [31:0] exp_q[$];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic exp_mode;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (bus.md_valid === 1'b1) issues++;

  // unsigned iterative unit model
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic m;
    bus.md_ready = 1'b0;
    bus.md_out = '0;
    forever begin
      @(negedge clk);
      if (bus.md_valid === 1'b1) begin
        a = bus.md_a;
        b = bus.md_b;
        m = bus.md_mode;
        chk("md_a", a, exp_a);
        chk("md_b", b, exp_b);
        chk("md_mode", m, exp_mode);
        repeat (unit_dly) @(negedge clk);
        bus.md_ready = 1'b1;
        if (!m)
          bus.md_out = {32'd0, a} * {32'd0, b};
        else if (b != 0)
          bus.md_out = {a % b, a / b};
        else
          bus.md_out = '0;
        @(negedge clk);
        bus.md_ready = 1'b0;
        bus.md_out = '0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL resp_unexpected act=%h exp=none",
                   bus.resp_data);
        end else begin
          chk("resp_data", bus.resp_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic run(string nm, logic [2:0] op,
                     logic [31:0] r1, logic [31:0] r2,
                     logic [31:0] exp, logic [31:0] ea,
                     logic [31:0] eb, bit byp);
    int c;
    int i0;
    bit st_ok;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_rs1 = r1;
    bus.req_rs2 = r2;
    exp_q.push_back(exp);
    exp_a = ea;
    exp_b = eb;
    exp_mode = op[2];
    i0 = issues;
    #1 chk({nm, " stall_accept"}, bus.stall, 1);
    @(posedge clk);
    c = 0;
    st_ok = 1'b1;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (bus.resp_valid === 1'b1) break;
      if (bus.stall !== 1'b1) st_ok = 1'b0;
    end
    chk({nm, " latency"}, c, byp ? 1 : unit_dly + 2);
    chk({nm, " stall_hold"}, st_ok, 1);
    chk({nm, " stall_done"}, bus.stall, 0);
    chk({nm, " issues"}, issues - i0, byp ? 0 : 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_reset(string nm);
    chk({nm, " stall"}, bus.stall, 0);
    chk({nm, " resp_valid"}, bus.resp_valid, 0);
    chk({nm, " resp_data"}, bus.resp_data, 0);
    chk({nm, " md_valid"}, bus.md_valid, 0);
    chk({nm, " md_mode"}, bus.md_mode, 0);
    chk({nm, " md_a"}, bus.md_a, 0);
    chk({nm, " md_b"}, bus.md_b, 0);
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    run("mul",    3'b000, 32'd7, 32'd6, 32'd42, 32'd7, 32'd6, 0);
    run("mulh",   3'b001, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFFF, 32'd3, 32'd5, 0);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 0);
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFD, 32'd7, 32'd2, 0);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'd7, 32'd2, 0);
    run("remu",   3'b111, 32'd7, 32'd2, 32'd1, 32'd7, 32'd2, 0);
    run("div_min2", 3'b100, 32'h80000000, 32'd2,
        32'hC0000000, 32'h80000000, 32'd2, 0);
    run("divu_big", 3'b101, 32'h80000000, 32'hFFFFFFFF,
        32'd0, 32'h80000000, 32'hFFFFFFFF, 0);

    run("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0, 1);
    run("rem_z",  3'b110, 32'd5, 32'd0, 32'd5, 0, 0, 1);
    run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 0, 0, 1);
    run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
        32'd0, 0, 0, 1);

    unit_dly = 1;
    run("mul_fast", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

    // reset while waiting; the unit answers afterwards
    unit_dly = 20;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = 3'b101;
    bus.req_rs1 = 32'd100;
    bus.req_rs2 = 32'd7;
    exp_a = 32'd100;
    exp_b = 32'd7;
    exp_mode = 1'b1;
    r0 = n_resp;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_reset("wait_rst");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("wait_rst no_resp", n_resp - r0, 0);
    chk("wait_rst stall_after", bus.stall, 0);

    unit_dly = 33;
    run("mul_after_rst", 3'b000, 32'd3, 32'd3,
        32'd9, 32'd3, 32'd3, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Initiator side of the iterative multiply/divide handshake. Accepts an RV32M request from the execute stage, applies RISC-V sign pre-processing, and issues a one-cycle `md_valid` to the shared unsigned multiply/divide unit. It waits for `md_ready`, applies sign post-correction and high/low word selection, and returns a 32-bit result. It holds the pipeline stalled for the whole transaction and resolves divide-by-zero and signed-overflow locally, without issuing to the unit.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  M-extension instruction present in EX; held stable with its operands while `stall`=1.
- `req_op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_rs1`, `req_rs2`  in  32  operands.
- `stall`  out  1  freeze upstream pipeline.
- `resp_valid`  out  1  one-cycle result strobe.
- `resp_data`  out  32  result, valid while `resp_valid`=1.
- `md_valid`  out  1  start pulse to the unit.
- `md_mode`  out  1  0 = unsigned multiply, 1 = unsigned divide.
- `md_a`, `md_b`  out  32  unsigned operands: multiplicand/multiplier or dividend/divisor.
- `md_ready`  in  1  unit result valid (one cycle).
- `md_out`  in  64  multiply: 64-bit product. Divide: [31:0] quotient, [63:32] remainder.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, `req_valid`=1:
  - Latch op, operand signs s1/s2, and magnitudes |rs1|/|rs2|.
  - Take the magnitude only where the operand is signed: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  - |0x80000000| = 0x80000000, treated as unsigned.
  - Divisor = 0:
    - DIV/DIVU result 0xFFFFFFFF.
    - REM/REMU result rs1.
    - Go to DONE.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF:
    - DIV result 0x80000000, REM result 0.
    - Go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: `md_valid`=1 for exactly this cycle, with `md_mode`=op[2] and `md_a`/`md_b` = latched magnitudes. Go to WAIT.
- WAIT:
  - `md_a`/`md_b`/`md_mode` stay held and `md_valid`=0.
  - On `md_ready`=1, register the corrected result and go to DONE. Correction rules:
  - MUL: `md_out[31:0]` (sign-independent).
  - MULHU: `md_out[63:32]`.
  - MULH: negate the 64-bit product if s1^s2, then take [63:32].
  - MULHSU: negate the 64-bit product if s1, then take [63:32].
  - DIVU: quotient. REMU: remainder.
  - DIV: quotient, negated if s1^s2.
  - REM: remainder, negated if s1.
  - Negation is two's complement, modulo 2^64 or 2^32 respectively.
- DONE: `resp_valid`=1 and `stall`=0. Go to IDLE unconditionally; `req_valid` is ignored in DONE.
- `stall` = (IDLE & `req_valid`) | ISSUE | WAIT.
- `md_ready` is honoured only in WAIT and ignored in every other state.
- The unit must be reset from the same reset source.

## Timing
- Reset values:
  - state IDLE.
  - `stall`=0 (when `req_valid`=0), `resp_valid`=0, `resp_data`=0.
  - `md_valid`=0, `md_mode`=0, `md_a`=`md_b`=0.
- Accept at cycle 0 (IDLE, `req_valid`=1):
  - ISSUE at cycle 1.
  - WAIT from cycle 2; `md_ready` arrives at cycle k ≥ 2.
  - DONE at cycle k+1, giving latency k+1.
  - With the current 32-iteration unit, k = 34, so `resp_valid` is at cycle 35.
- Local bypass (zero divisor or overflow): DONE at cycle 1; `md_valid` never asserts.
- Back-to-back requests: the next accept occurs no earlier than the cycle after DONE.
- `rst`=1 in any state, including WAIT: IDLE on the next edge, all outputs return to reset values, and any late `md_ready` is discarded.

## Test plan
- MUL 7 × 6 → single `md_valid` pulse with `md_a`=7, `md_b`=6. `resp_data`=42 one cycle after `md_ready`; `stall` high from cycle 0 through WAIT.
- MULH 0xFFFFFFFD × 5 → `md_a`=3, `md_b`=5, `resp_data`=0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → `md_a`=7, `md_b`=2, `resp_data`=0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. REMU 7/2 → 1.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5. Both with `resp_valid` at cycle 1 and no `md_valid`.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. Latency 1, no issue.
- Assert `rst` in WAIT, then pulse `md_ready` → no `resp_valid`, `stall`=0. The next MUL 3 × 3 → 9.
